program_loader: RTL
===================

Name: program_loader

Overview:
Upstream feeder for the 4-bit CPU. Accepts a stream of 11-bit instructions over a valid/ready handshake and clears the CPU state. Writes the words into CPU program RAM rows 0..DEPTH-1 through the CPU's RAM_Write_* port, then releases the CPU to run by raising PC_Enable. Supports reload and halt without a global reset.

Parameters:
INSTR_W, 11, instruction width; must match the CPU RAM word
ADDR_W, 3, RAM address width
DEPTH, 8, number of RAM rows; equals 2**ADDR_W

Ports:
clk  in  1  system clock, same clock as the CPU
reset  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse; begins a load from IDLE, RUN or ERROR
halt  in  1  in RUN, stops the CPU and returns to IDLE
in_valid  in  1  stream word valid
in_data  in  INSTR_W  stream word
in_last  in  1  marks the final program word
in_ready  out  1  loader accepts a word this cycle
cpu_reset  out  1  drives the CPU reset input
PC_Enable  out  1  drives CPU PC_Enable
RAM_Write_Data  out  INSTR_W  to CPU RAM_Write_Data
RAM_Write_Address  out  ADDR_W  to CPU RAM_Write_Address
RAM_Write_Enable  out  1  to CPU RAM_Write_Enable
loaded_count  out  ADDR_W+1  words written in the current or last load
busy  out  1  high in CLEAR, LOAD, FLUSH and CHECK
overflow  out  1  sticky: DEPTH words received without in_last
error  out  1  sticky checksum failure; 0 when the feature is compiled out

Behaviour:
- Reset: state IDLE. All outputs are 0, including in_ready, cpu_reset, PC_Enable, RAM_Write_*, loaded_count, overflow and error. The address counter is 0.
- All outputs are registered except in_ready, which is decoded combinationally from state (high only in LOAD, and in CHECK when the feature is enabled).
- Handshake: a word is accepted when in_valid && in_ready. in_data and in_last are sampled only on acceptance. in_valid without in_ready is ignored.
- States:
  - IDLE: waits. start -> CLEAR.
  - CLEAR: exactly 1 cycle. cpu_reset=1 for that cycle, which clears the CPU PC, flags, registers and RAM. Also clears the address counter, loaded_count, overflow and error. -> LOAD.
  - LOAD: on each acceptance, the next cycle shows:
    - RAM_Write_Enable=1
    - RAM_Write_Data=in_data
    - RAM_Write_Address=counter
    - counter and loaded_count incremented
  - LOAD exit:
    - Acceptance with in_last=1 -> FLUSH (or CHECK when the feature is enabled).
    - Acceptance of the DEPTH-th word with in_last=0 -> FLUSH and overflow=1. The counter does not wrap into row 0.
  - FLUSH: 1 cycle; the final write pulse is visible here. -> RUN.
  - RUN: PC_Enable=1. The first cycle with PC_Enable=1 is strictly after the last RAM_Write_Enable pulse.
    - halt -> IDLE, with PC_Enable=0 the next cycle. RAM contents are kept.
    - start -> CLEAR (reload).
- RAM_Write_Enable is 1 for exactly one cycle per accepted word. Otherwise it is 0, and RAM_Write_Data/RAM_Write_Address hold their last values.
- PC_Enable is 0 in every state except RUN. cpu_reset is 1 only in CLEAR.
- start is ignored in CLEAR, LOAD, FLUSH and CHECK. halt is ignored outside RUN.
- If start and halt arrive in the same RUN cycle, start wins.
- reset mid-load aborts immediately to the reset values. Partially written RAM is left as written.

Optional Feature:
Macro: PROGRAM_LOADER_CHECKSUM_EN
- Enabled: the loader keeps a running XOR of all accepted program words; CLEAR zeroes it.
  - After the in_last word, or after the DEPTH-th word, the state goes to CHECK. In CHECK, in_ready=1 and one more beat is accepted as the checksum; its in_last is ignored.
  - Checksum match -> FLUSH -> RUN.
  - Mismatch -> ERROR. In ERROR: error=1 and PC_Enable=0. start -> CLEAR.
- Disabled: no CHECK or ERROR state, no XOR logic, error tied to 0.

Test Plan:
- Reset, start, stream 3 words 0x101, 0x202, 0x4FF (in_last on the third) -> one cpu_reset pulse, then writes to rows 0/1/2 with those values. loaded_count=3. PC_Enable rises exactly 2 cycles after the third acceptance and stays high.
- Same stream with in_valid toggled 1-0-1-0 -> writes only on accepted cycles, no duplicates, same final rows and count.
- Stream 9 words with no in_last -> rows 0..7 written, 9th word not accepted (in_ready=0), overflow=1, loaded_count=8, then RUN.
- In RUN, pulse halt -> PC_Enable=0 the next cycle, state IDLE. Then pulse start -> cpu_reset pulse, new load.
- Assert reset after 2 of 4 words -> all outputs 0 the next cycle, in_ready=0, PC_Enable never asserts.
- With PROGRAM_LOADER_CHECKSUM_EN, words 0x0F0 and 0x00F:
  - Checksum 0x0FF -> RUN.
  - Checksum 0x0FE -> error=1 and PC_Enable stays 0. A following start clears error.

Source files
------------

// File: rtl/program_loader.sv
// Streams INSTR_W-bit words into the CPU program RAM, then releases the CPU via PC_Enable.
// Optional checksum beat after the program is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int INSTR_W = 11,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               cpu_reset,
    output logic               PC_Enable,
    output logic [INSTR_W-1:0] RAM_Write_Data,
    output logic [ADDR_W-1:0]  RAM_Write_Address,
    output logic               RAM_Write_Enable,
    output logic [ADDR_W:0]    loaded_count,
    output logic               busy,
    output logic               overflow,
    output logic               error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_FLUSH, S_RUN, S_CHECK, S_ERROR} state_t;
    localparam state_t S_POST = S_CHECK;
`else
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_FLUSH, S_RUN} state_t;
    localparam state_t S_POST = S_FLUSH;
`endif

    localparam logic [ADDR_W:0] LAST_ROW = (ADDR_W+1)'(DEPTH - 1);

    state_t               state_q, state_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 pc_enable_q, pc_enable_d;
    logic                 wr_en_q, wr_en_d;
    logic [INSTR_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;
    logic                 accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic                 error_q, error_d;
    logic [INSTR_W-1:0]   csum_q, csum_d;
`endif

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    assign in_ready = (state_q == S_LOAD);
`endif
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        error_d    = error_q;
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = in_data;
                    wr_addr_d = count_q[ADDR_W-1:0];
                    count_d   = count_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ in_data;
`endif
                    if (in_last) begin
                        state_d = S_POST;
                    end else if (count_q == LAST_ROW) begin
                        // Table full without a terminator: stop rather than wrap onto row 0.
                        state_d    = S_POST;
                        overflow_d = 1'b1;
                    end
                end
            end
            S_FLUSH: state_d = S_RUN;
            S_RUN: begin
                if (start)     state_d = S_CLEAR;
                else if (halt) state_d = S_IDLE;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            S_ERROR: if (start) state_d = S_CLEAR;
`endif
            default: state_d = S_IDLE;
        endcase

        // Entering CLEAR wipes the per-load bookkeeping so it reads 0 during the CPU reset pulse.
        if (state_d == S_CLEAR) begin
            count_d    = '0;
            overflow_d = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            error_d    = 1'b0;
            csum_d     = '0;
`endif
        end

        cpu_reset_d = (state_d == S_CLEAR);
        pc_enable_d = (state_d == S_RUN);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        busy_d = (state_d == S_CLEAR) || (state_d == S_LOAD) ||
                 (state_d == S_FLUSH) || (state_d == S_CHECK);
`else
        busy_d = (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_FLUSH);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cpu_reset_q <= 1'b0;
            pc_enable_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            error_q     <= 1'b0;
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            pc_enable_q <= pc_enable_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            error_q     <= error_d;
            csum_q      <= csum_d;
`endif
        end
    end

    assign cpu_reset         = cpu_reset_q;
    assign PC_Enable         = pc_enable_q;
    assign RAM_Write_Enable  = wr_en_q;
    assign RAM_Write_Data    = wr_data_q;
    assign RAM_Write_Address = wr_addr_q;
    assign loaded_count      = count_q;
    assign busy              = busy_q;
    assign overflow          = overflow_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign error             = error_q;
`else
    assign error             = 1'b0;
`endif

endmodule
